// File: rtl/reg_pkg.sv
// Shared definitions for the register file and its load scoreboard.
// Holds the default datapath geometry, the address/data typedefs for the
// default configuration and the default load-destination register index.
package reg_pkg;

    localparam int W_DEF        = 8;
    localparam int D_DEF        = 3;
    localparam int NREG_DEF     = 2 ** D_DEF;
    localparam int LOAD_DST_DEF = NREG_DEF - 1;
    localparam int MAX_LD_DEF   = 3;
    localparam int LD_CNT_W     = 4;

    typedef logic [W_DEF-1:0]    reg_data_t;
    typedef logic [D_DEF-1:0]    reg_addr_t;
    typedef logic [LD_CNT_W-1:0] ld_cnt_t;

endpackage

// File: rtl/reg_file_sb_if.sv
// Bus bundle between decode/writeback and the register file.
// master : decode + writeback side (drives addresses, write data, load events)
// slave  : register file (returns read data, stall, scoreboard status)
interface reg_file_sb_if
    import reg_pkg::*;
#(
    parameter int W = W_DEF,
    parameter int D = D_DEF
);

    logic [D-1:0]        raddr_a;
    logic [D-1:0]        raddr_b;
    logic                b_imm;
    logic                we;
    logic [D-1:0]        waddr;
    logic [W-1:0]        wdata;
    logic                ld_issue;
    logic                ld_valid;
    logic [W-1:0]        ld_data;
    logic [W-1:0]        data_out_a;
    logic [W-1:0]        data_out_b;
    logic                stall;
    logic [LD_CNT_W-1:0] ld_pending;
    logic                ld_err;

    modport master (
        output raddr_a, raddr_b, b_imm, we, waddr, wdata,
               ld_issue, ld_valid, ld_data,
        input  data_out_a, data_out_b, stall, ld_pending, ld_err
    );

    modport slave (
        input  raddr_a, raddr_b, b_imm, we, waddr, wdata,
               ld_issue, ld_valid, ld_data,
        output data_out_a, data_out_b, stall, ld_pending, ld_err
    );

endinterface

// File: rtl/ld_scoreboard.sv
// Outstanding-load tracker for the load-destination register.
// Ports:
//   clk, rst_n   : clock, async active-low reset
//   ld_issue     : a load has been issued
//   ld_valid     : load data returns this cycle
//   ld_cnt       : outstanding load count (0..MAX_LD)
//   busy         : at least one load outstanding
//   last_return  : the final outstanding load returns this cycle with no new issue
//   ld_err       : sticky flag for issue-at-full or return-at-empty
module ld_scoreboard
    import reg_pkg::*;
#(
    parameter int MAX_LD = MAX_LD_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ld_issue,
    input  logic                ld_valid,
    output logic [LD_CNT_W-1:0] ld_cnt,
    output logic                busy,
    output logic                last_return,
    output logic                ld_err
);

    localparam logic [LD_CNT_W-1:0] CNT_MAX = LD_CNT_W'(MAX_LD);

    logic [LD_CNT_W-1:0] cnt_q, cnt_d;
    logic                err_q, err_d;

    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        unique case ({ld_issue, ld_valid})
            2'b10: begin
                // an issue beyond the tracking depth is dropped, not counted
                if (cnt_q == CNT_MAX) err_d = 1'b1;
                else                  cnt_d = cnt_q + 1'b1;
            end
            2'b01: begin
                if (cnt_q == '0) err_d = 1'b1;
                else             cnt_d = cnt_q - 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign ld_cnt      = cnt_q;
    assign busy        = (cnt_q != '0);
    assign last_return = (cnt_q == LD_CNT_W'(1)) && ld_valid && !ld_issue;
    assign ld_err      = err_q;

endmodule

// File: rtl/reg_file_sb.sv
// Register file with write bypass and outstanding-load scoreboard.
// Two combinational read ports (port B may return an immediate), one ALU
// write port and one load write port into the fixed LOAD_DST register.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   bus        : reg_file_sb_if.slave -- read addresses, write ports, load
//                events in; read data, stall, ld_pending, ld_err out
module reg_file_sb
    import reg_pkg::*;
#(
    parameter int W        = W_DEF,
    parameter int D        = D_DEF,
    parameter int LOAD_DST = LOAD_DST_DEF,
    parameter int MAX_LD   = MAX_LD_DEF,
    parameter int ZERO_R0  = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    reg_file_sb_if.slave  bus
);

    localparam int           NREG    = 2 ** D;
    localparam logic [D-1:0] LD_ADDR = D'(LOAD_DST);
    localparam bit           ZR0     = (ZERO_R0 != 0);

    logic [W-1:0] regs_q [NREG];
    logic [W-1:0] regs_d [NREG];

    logic busy;
    logic last_return;
    logic touch_ld;
    logic stall;
    logic ld_wr;
    logic alu_wr;
    logic [W-1:0] rd_a;
    logic [W-1:0] rd_b;

    ld_scoreboard #(
        .MAX_LD (MAX_LD)
    ) u_sb (
        .clk         (clk),
        .rst_n       (rst_n),
        .ld_issue    (bus.ld_issue),
        .ld_valid    (bus.ld_valid),
        .ld_cnt      (bus.ld_pending),
        .busy        (busy),
        .last_return (last_return),
        .ld_err      (bus.ld_err)
    );

    // Port B in immediate mode never touches the register array.
    assign touch_ld = (bus.raddr_a == LD_ADDR)
                    || (!bus.b_imm && (bus.raddr_b == LD_ADDR))
                    || (bus.we && (bus.waddr == LD_ADDR));

    // The last returning load satisfies its consumer through the bypass.
    assign stall = busy && touch_ld && !last_return;

    assign ld_wr  = bus.ld_valid && !(ZR0 && (LD_ADDR == '0));
    assign alu_wr = bus.we && !stall
                  && !(ZR0 && (bus.waddr == '0))
                  && !(bus.ld_valid && (bus.waddr == LD_ADDR));

    always_comb begin
        regs_d = regs_q;
        if (alu_wr) regs_d[bus.waddr] = bus.wdata;
        if (ld_wr)  regs_d[LD_ADDR]   = bus.ld_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    // Bypass only writes that actually commit; load data has priority.
    always_comb begin
        rd_a = regs_q[bus.raddr_a];
        if (alu_wr && (bus.waddr == bus.raddr_a)) rd_a = bus.wdata;
        if (ld_wr && (LD_ADDR == bus.raddr_a))    rd_a = bus.ld_data;

        rd_b = regs_q[bus.raddr_b];
        if (alu_wr && (bus.waddr == bus.raddr_b)) rd_b = bus.wdata;
        if (ld_wr && (LD_ADDR == bus.raddr_b))    rd_b = bus.ld_data;
        if (bus.b_imm)                            rd_b = W'(bus.raddr_b);
    end

    assign bus.data_out_a = rd_a;
    assign bus.data_out_b = rd_b;
    assign bus.stall      = stall;

endmodule

// File: tb/tb_reg_file_sb.sv
module tb_reg_file_sb;
    import reg_pkg::*;

    localparam int LD_IDX = 7;
    localparam int MAXLD  = 3;

    logic clk;
    logic rst_n;

    reg_file_sb_if bus ();

    reg_file_sb dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    // reference model state
    int mdl_regs [8];
    int mdl_cnt;
    bit mdl_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic mdl_reset();
        for (int i = 0; i < 8; i++) mdl_regs[i] = 0;
        mdl_cnt = 0;
        mdl_err = 0;
    endtask

    function automatic bit exp_stall();
        bit touch;
        touch = (int'(bus.raddr_a) == LD_IDX)
             || (!bus.b_imm && int'(bus.raddr_b) == LD_IDX)
             || (bus.we && int'(bus.waddr) == LD_IDX);
        if (mdl_cnt == 0 || !touch) return 0;
        if (mdl_cnt == 1 && bus.ld_valid && !bus.ld_issue) return 0;
        return 1;
    endfunction

    function automatic int exp_read(input int addr, input bit stl);
        if (bus.ld_valid && addr == LD_IDX) return int'(bus.ld_data);
        if (bus.we && !stl && int'(bus.waddr) == addr) return int'(bus.wdata);
        return mdl_regs[addr];
    endfunction

    // Check all outputs mid-cycle, then advance the model over the rising edge.
    task automatic step(input string tag);
        bit stl;
        int eb;
        @(negedge clk);
        stl = exp_stall();
        eb  = bus.b_imm ? int'(bus.raddr_b) : exp_read(int'(bus.raddr_b), stl);
        check({tag, ".stall"},   32'(bus.stall),      32'(stl));
        check({tag, ".a"},       32'(bus.data_out_a), 32'(exp_read(int'(bus.raddr_a), stl)));
        check({tag, ".b"},       32'(bus.data_out_b), 32'(eb));
        check({tag, ".pending"}, 32'(bus.ld_pending), 32'(mdl_cnt));
        check({tag, ".err"},     32'(bus.ld_err),     32'(mdl_err));
        @(posedge clk);
        if (bus.we && !stl) mdl_regs[bus.waddr] = int'(bus.wdata);
        if (bus.ld_valid)   mdl_regs[LD_IDX]    = int'(bus.ld_data);
        if (bus.ld_issue && !bus.ld_valid) begin
            if (mdl_cnt == MAXLD) mdl_err = 1;
            else                  mdl_cnt++;
        end else if (bus.ld_valid && !bus.ld_issue) begin
            if (mdl_cnt == 0) mdl_err = 1;
            else              mdl_cnt--;
        end
        #1;
    endtask

    task automatic idle_inputs();
        bus.raddr_a  = '0;
        bus.raddr_b  = '0;
        bus.b_imm    = 1'b0;
        bus.we       = 1'b0;
        bus.waddr    = '0;
        bus.wdata    = '0;
        bus.ld_issue = 1'b0;
        bus.ld_valid = 1'b0;
        bus.ld_data  = '0;
    endtask

    task automatic async_reset_check(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        check({tag, ".rst_a"},       32'(bus.data_out_a), 32'h0);
        check({tag, ".rst_b"},       32'(bus.data_out_b), 32'h0);
        check({tag, ".rst_stall"},   32'(bus.stall),      32'h0);
        check({tag, ".rst_pending"}, 32'(bus.ld_pending), 32'h0);
        check({tag, ".rst_err"},     32'(bus.ld_err),     32'h0);
        mdl_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        mdl_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // 1: reset state
        @(negedge clk);
        check("t1.a",       32'(bus.data_out_a), 32'h0);
        check("t1.b",       32'(bus.data_out_b), 32'h0);
        check("t1.stall",   32'(bus.stall),      32'h0);
        check("t1.pending", 32'(bus.ld_pending), 32'h0);
        check("t1.err",     32'(bus.ld_err),     32'h0);
        @(posedge clk); #1;

        // 2: ALU write bypass, then storage read
        bus.we = 1'b1; bus.waddr = 3'd2; bus.wdata = 8'hA5; bus.raddr_a = 3'd2;
        #1 check("t2.bypass", 32'(bus.data_out_a), 32'hA5);
        step("t2w");
        bus.we = 1'b0;
        #1 check("t2.stored", 32'(bus.data_out_a), 32'hA5);
        step("t2r");

        // 3: immediate on port B
        bus.b_imm = 1'b1; bus.raddr_b = 3'd5; bus.raddr_a = 3'd2;
        #1 check("t3.imm", 32'(bus.data_out_b), 32'h05);
        step("t3");

        // 4: scoreboard + last-load bypass
        bus.b_imm = 1'b0; bus.raddr_b = 3'd0; bus.ld_issue = 1'b1;
        step("t4i");
        bus.ld_issue = 1'b0;
        #1 check("t4.pending1", 32'(bus.ld_pending), 32'h1);
        bus.b_imm = 1'b1; bus.raddr_b = 3'd7;
        #1 check("t4.imm_nostall", 32'(bus.stall), 32'h0);
        step("t4imm");
        bus.b_imm = 1'b0; bus.raddr_b = 3'd0; bus.raddr_a = 3'd7;
        #1 check("t4.stall", 32'(bus.stall), 32'h1);
        step("t4s");
        bus.ld_valid = 1'b1; bus.ld_data = 8'h3C;
        #1 check("t4.ret_stall", 32'(bus.stall), 32'h0);
        check("t4.ret_a", 32'(bus.data_out_a), 32'h3C);
        step("t4v");
        bus.ld_valid = 1'b0;
        #1 check("t4.pending0", 32'(bus.ld_pending), 32'h0);
        check("t4.r7", 32'(bus.data_out_a), 32'h3C);
        step("t4r");

        // 5: load beats ALU on LOAD_DST
        bus.raddr_a = 3'd1; bus.ld_issue = 1'b1;
        step("t5i");
        bus.ld_issue = 1'b0; bus.raddr_a = 3'd7;
        bus.we = 1'b1; bus.waddr = 3'd7; bus.wdata = 8'h11;
        bus.ld_valid = 1'b1; bus.ld_data = 8'h22;
        #1 check("t5.bypass", 32'(bus.data_out_a), 32'h22);
        step("t5w");
        idle_inputs(); bus.raddr_a = 3'd7;
        #1 check("t5.r7", 32'(bus.data_out_a), 32'h22);
        step("t5r");

        // 6: saturation, error, async reset mid-cycle
        bus.raddr_a = 3'd1; bus.ld_issue = 1'b1;
        repeat (4) step("t6i");
        bus.ld_issue = 1'b0;
        #1 check("t6.sat", 32'(bus.ld_pending), 32'h3);
        check("t6.err", 32'(bus.ld_err), 32'h1);
        bus.raddr_a = 3'd7;
        async_reset_check("t6");

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            bus.raddr_a  = 3'($urandom_range(0, 7));
            bus.raddr_b  = 3'($urandom_range(0, 7));
            bus.b_imm    = ($urandom_range(0, 3) == 0);
            bus.we       = $urandom_range(0, 1) != 0;
            bus.waddr    = 3'($urandom_range(0, 7));
            bus.wdata    = 8'($urandom);
            bus.ld_issue = ($urandom_range(0, 9) < 3);
            bus.ld_valid = ($urandom_range(0, 9) < 3);
            bus.ld_data  = 8'($urandom);
            step("rnd");
            if (i == 200) begin
                idle_inputs();
                async_reset_check("rnd");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
